// File: rtl/load_store_queue.sv
// Load/store queue: circular FIFO of memory requests drained one at a time
// through a byte-wide memory port, with flush, pause and per-request completion.
module load_store_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned ID_WIDTH    = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush_pipline,
    input  logic                have_ins,
    input  logic [ID_WIDTH-1:0] ins_id,
    input  logic [31:0]         rs1_val,
    input  logic [31:0]         imm_val,
    input  logic [31:0]         rs2_val,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    output logic                queue_full,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic [31:0]         mem_a,
    output logic [7:0]          mem_dout,
    output logic                mem_wr,
    input  logic [7:0]          mem_din,
    output logic                res_valid,
    output logic [ID_WIDTH-1:0] res_ins_id,
    output logic [31:0]         res_val
);
    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StIdle, StReq, StXfer} state_e;

    logic [ID_WIDTH-1:0] r_q_id   [QUEUE_DEPTH];
    logic [31:0]         r_q_addr [QUEUE_DEPTH];
    logic [31:0]         r_q_data [QUEUE_DEPTH];
    logic                r_q_st   [QUEUE_DEPTH];
    logic [2:0]          r_q_f3   [QUEUE_DEPTH];

    logic [PW-1:0]       r_head, r_tail;
    logic [CW-1:0]       r_count;
    state_e              r_state, w_next;
    logic [2:0]          r_cnt;
    logic [ID_WIDTH-1:0] r_x_id;
    logic [31:0]         r_x_addr, r_x_data, r_ld;
    logic                r_x_st, r_kill;
    logic [2:0]          r_x_f3;

    logic [2:0]  w_n;
    logic        w_last, w_enq, w_done, w_pop, w_start;
    logic [1:0]  w_bidx;
    logic [31:0] w_ld, w_res;

    assign queue_full = (r_count == CW'(QUEUE_DEPTH));
    assign w_last  = r_x_st ? (r_cnt == w_n - 3'd1) : (r_cnt == w_n);
    assign w_enq   = rdy_in & have_ins & ~flush_pipline & ~queue_full;
    assign w_done  = rdy_in & (r_state == StXfer) & w_last;
    // A store that survived a flush finishes its bytes but has no queue entry left to pop.
    assign w_pop   = w_done & ~r_kill;
    assign w_start = rdy_in & ~flush_pipline & (r_state == StReq) & mem_gnt;
    assign w_bidx  = r_cnt[1:0] - 2'd1;

    always_comb begin
        case (r_x_f3[1:0])
            2'b00:   w_n = 3'd1;
            2'b01:   w_n = 3'd2;
            default: w_n = 3'd4;
        endcase
    end

    // mem_din answers the address of the previous cycle, so it lands in byte cnt-1.
    always_comb begin
        w_ld = r_ld;
        w_ld[{w_bidx, 3'b000} +: 8] = mem_din;
        case (r_x_f3)
            3'b000:  w_res = {{24{w_ld[7]}}, w_ld[7:0]};
            3'b001:  w_res = {{16{w_ld[15]}}, w_ld[15:0]};
            3'b100:  w_res = {24'd0, w_ld[7:0]};
            3'b101:  w_res = {16'd0, w_ld[15:0]};
            default: w_res = w_ld;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= StIdle;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (rdy_in) begin
            case (r_state)
                StIdle: if (!flush_pipline && r_count != '0) w_next = StReq;
                StReq: begin
                    if (flush_pipline) w_next = StIdle;
                    else if (mem_gnt)  w_next = StXfer;
                end
                StXfer: if (w_last || (flush_pipline && !r_x_st)) w_next = StIdle;
                default: w_next = StIdle;
            endcase
        end
    end

    always_comb begin
        mem_req  = (r_state != StIdle);
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        if (r_state == StXfer && r_cnt < w_n) begin
            mem_a = r_x_addr + 32'(r_cnt);
            if (r_x_st) begin
                mem_wr   = rdy_in;
                mem_dout = r_x_data[{r_cnt[1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_enq) begin
            r_q_id[r_tail]   <= ins_id;
            r_q_addr[r_tail] <= rs1_val + imm_val;
            r_q_data[r_tail] <= rs2_val;
            r_q_st[r_tail]   <= is_store;
            r_q_f3[r_tail]   <= funct3;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy_in) begin
            if (flush_pipline) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) r_tail <= r_tail + 1'b1;
                if (w_pop) r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_enq) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt    <= '0;
            r_x_id   <= '0;
            r_x_addr <= '0;
            r_x_data <= '0;
            r_x_st   <= 1'b0;
            r_x_f3   <= '0;
            r_ld     <= '0;
            r_kill   <= 1'b0;
        end else if (rdy_in) begin
            if (w_start) begin
                r_cnt    <= '0;
                r_x_id   <= r_q_id[r_head];
                r_x_addr <= r_q_addr[r_head];
                r_x_data <= r_q_data[r_head];
                r_x_st   <= r_q_st[r_head];
                r_x_f3   <= r_q_f3[r_head];
                r_kill   <= 1'b0;
            end else if (r_state == StXfer) begin
                r_cnt <= r_cnt + 3'd1;
                if (!r_x_st && r_cnt != '0) r_ld <= w_ld;
                if (w_last)                             r_kill <= 1'b0;
                else if (flush_pipline && r_x_st)       r_kill <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            res_valid  <= 1'b0;
            res_ins_id <= '0;
            res_val    <= '0;
        end else if (rdy_in) begin
            res_valid <= w_pop & ~flush_pipline;
            if (w_pop && !flush_pipline) begin
                res_ins_id <= r_x_id;
                res_val    <= r_x_st ? 32'd0 : w_res;
            end
        end
    end
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: byte-wide memory model with one-cycle read latency.
module tb_load_store_queue;
    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush_pipline, have_ins, is_store, mem_gnt;
    logic [2:0]  ins_id, funct3, res_ins_id;
    logic [31:0] rs1_val, imm_val, rs2_val, mem_a, res_val;
    logic        queue_full, mem_req, mem_wr, res_valid;
    logic [7:0]  mem_dout, mem_din;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    load_store_queue #(.QUEUE_DEPTH(4), .ID_WIDTH(3)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
        .have_ins(have_ins), .ins_id(ins_id), .rs1_val(rs1_val), .imm_val(imm_val),
        .rs2_val(rs2_val), .is_store(is_store), .funct3(funct3), .queue_full(queue_full),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .res_valid(res_valid), .res_ins_id(res_ins_id),
        .res_val(res_val)
    );

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h0000_00FC: return 8'h80;
            32'hFFFF_FFFF: return 8'h34;
            32'h0000_0000: return 8'h12;
            32'h0000_0200: return 8'h10;
            32'h0000_0201: return 8'h11;
            32'h0000_0202: return 8'h12;
            32'h0000_0203: return 8'h13;
            32'h0000_0400: return 8'h11;
            32'h0000_0401: return 8'h22;
            32'h0000_0402: return 8'h33;
            32'h0000_0403: return 8'h44;
            default:       return 8'h00;
        endcase
    endfunction

    // Read data follows the address by one cycle and freezes while paused.
    always @(posedge clk) if (rdy_in) mem_din <= byte_at(mem_a);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic enq(input logic [2:0] id, input logic [31:0] a, input logic [31:0] off,
                       input logic [31:0] d, input logic st, input logic [2:0] f3);
        have_ins = 1'b1; ins_id = id; rs1_val = a; imm_val = off; rs2_val = d;
        is_store = st; funct3 = f3;
        tick();
        have_ins = 1'b0;
    endtask

    task automatic wait_a(input logic [31:0] a, input string tag);
        int k = 0;
        while (mem_a !== a && k < 20) begin tick(); k++; end
        chk(tag, mem_a, a);
    endtask

    task automatic wait_res(input string tag);
        int k = 0;
        while (res_valid !== 1'b1 && k < 30) begin tick(); k++; end
        chk(tag, {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_v, cnt_r;
        logic [31:0] sd;
        rst_in = 1'b1; rdy_in = 1'b1; flush_pipline = 1'b0; have_ins = 1'b0; mem_gnt = 1'b1;
        ins_id = '0; rs1_val = '0; imm_val = '0; rs2_val = '0; is_store = 1'b0; funct3 = '0;
        #1 rst_in = 1'b0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_queue_full", {31'd0, queue_full}, 32'd0);
        tick(); tick();
        rst_in = 1'b1;
        tick();

        // Signed byte load, exact latency.
        enq(3'd1, 32'h100, 32'hFFFF_FFFC, 32'd0, 1'b0, 3'b000);
        chk("lb_idle", {31'd0, mem_req}, 32'd0);
        tick();
        chk("lb_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("lb_addr", mem_a, 32'hFC);
        chk("lb_wr", {31'd0, mem_wr}, 32'd0);
        tick();
        chk("lb_addr_once", mem_a, 32'd0);
        chk("lb_not_yet", {31'd0, res_valid}, 32'd0);
        tick();
        chk("lb_valid", {31'd0, res_valid}, 32'd1);
        chk("lb_val", res_val, 32'hFFFF_FF80);
        chk("lb_id", {29'd0, res_ins_id}, 32'd1);
        tick();
        chk("lb_valid_fall", {31'd0, res_valid}, 32'd0);

        // Misaligned word store.
        sd = 32'hA1B2_C3D4;
        enq(3'd2, 32'h1000, 32'd1, sd, 1'b1, 3'b010);
        wait_a(32'h1001, "sw_start");
        for (int i = 0; i < 4; i++) begin
            chk("sw_wr", {31'd0, mem_wr}, 32'd1);
            chk("sw_a", mem_a, 32'h1001 + 32'(i));
            chk("sw_dout", {24'd0, mem_dout}, {24'd0, sd[8*i +: 8]});
            tick();
        end
        chk("sw_wr_end", {31'd0, mem_wr}, 32'd0);
        chk("sw_valid", {31'd0, res_valid}, 32'd1);
        chk("sw_val", res_val, 32'd0);
        chk("sw_id", {29'd0, res_ins_id}, 32'd2);

        // Halfword load wrapping past the top of the address space.
        enq(3'd3, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 3'b101);
        wait_a(32'hFFFF_FFFF, "hu_a0");
        tick();
        chk("hu_a1", mem_a, 32'd0);
        wait_res("hu_valid");
        chk("hu_val", res_val, 32'h0000_1234);
        chk("hu_id", {29'd0, res_ins_id}, 32'd3);
        tick();

        // Fill the queue with no grant; the fifth request must be dropped.
        mem_gnt = 1'b0;
        have_ins = 1'b1; is_store = 1'b0; funct3 = 3'b100; imm_val = 32'd0;
        for (int i = 0; i < 5; i++) begin
            ins_id = (i < 4) ? 3'(4 + i) : 3'd1;
            rs1_val = 32'h200 + 32'(i);
            tick();
            if (i == 2) chk("not_full_at3", {31'd0, queue_full}, 32'd0);
            if (i == 3) chk("full_at4", {31'd0, queue_full}, 32'd1);
        end
        have_ins = 1'b0;
        chk("full_after5", {31'd0, queue_full}, 32'd1);
        mem_gnt = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_res("fifo_valid");
            chk("fifo_id", {29'd0, res_ins_id}, 32'(4 + j));
            chk("fifo_val", res_val, 32'h10 + 32'(j));
            tick();
        end
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid === 1'b1) cnt_v++;
            tick();
        end
        chk("fifo_no_fifth", 32'(cnt_v), 32'd0);
        chk("fifo_drained", {31'd0, queue_full}, 32'd0);

        // Flush during the second byte of a store with two loads behind it.
        enq(3'd2, 32'h300, 32'd0, 32'h5566_7788, 1'b1, 3'b010);
        enq(3'd5, 32'h400, 32'd0, 32'd0, 1'b0, 3'b010);
        enq(3'd6, 32'h200, 32'd0, 32'd0, 1'b0, 3'b000);
        wait_a(32'h300, "fl_b0");
        tick();
        chk("fl_b1", mem_a, 32'h301);
        flush_pipline = 1'b1;
        tick();
        flush_pipline = 1'b0;
        chk("fl_b2_a", mem_a, 32'h302);
        chk("fl_b2_d", {24'd0, mem_dout}, 32'h66);
        chk("fl_b2_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("fl_b3_a", mem_a, 32'h303);
        chk("fl_b3_d", {24'd0, mem_dout}, 32'h55);
        chk("fl_b3_wr", {31'd0, mem_wr}, 32'd1);
        cnt_v = 0; cnt_r = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (res_valid === 1'b1) cnt_v++;
            if (mem_req === 1'b1) cnt_r++;
        end
        chk("fl_no_res", 32'(cnt_v), 32'd0);
        chk("fl_queue_empty", 32'(cnt_r), 32'd0);

        // Three-cycle pause during a word load.
        enq(3'd7, 32'h400, 32'd0, 32'd0, 1'b0, 3'b010);
        wait_a(32'h400, "pz_a0");
        tick();
        chk("pz_a1", mem_a, 32'h401);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pz_hold_a", mem_a, 32'h401);
            chk("pz_hold_wr", {31'd0, mem_wr}, 32'd0);
        end
        rdy_in = 1'b1;
        wait_res("pz_valid");
        chk("pz_val", res_val, 32'h4433_2211);
        chk("pz_id", {29'd0, res_ins_id}, 32'd7);
        tick();

        // Pause in the middle of a store byte forces the write strobe low.
        enq(3'd3, 32'h500, 32'd0, 32'h9A, 1'b1, 3'b000);
        wait_a(32'h500, "pzs_a");
        chk("pzs_wr_on", {31'd0, mem_wr}, 32'd1);
        chk("pzs_dout", {24'd0, mem_dout}, 32'h9A);
        rdy_in = 1'b0;
        #1;
        chk("pzs_wr_forced", {31'd0, mem_wr}, 32'd0);
        tick();
        chk("pzs_hold_a", mem_a, 32'h500);
        rdy_in = 1'b1;
        #1;
        chk("pzs_wr_back", {31'd0, mem_wr}, 32'd1);
        wait_res("pzs_valid");
        chk("pzs_val", res_val, 32'd0);
        chk("pzs_id", {29'd0, res_ins_id}, 32'd3);
        tick();

        // Reset in the middle of a transfer with a full queue.
        mem_gnt = 1'b0;
        have_ins = 1'b1; ins_id = 3'd6; rs1_val = 32'h400; imm_val = 32'd0;
        is_store = 1'b0; funct3 = 3'b010;
        for (int i = 0; i < 4; i++) tick();
        have_ins = 1'b0;
        chk("rs_full", {31'd0, queue_full}, 32'd1);
        mem_gnt = 1'b1;
        wait_a(32'h400, "rs_a0");
        tick();
        rst_in = 1'b0;
        #1;
        chk("rs_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rs_mem_a", mem_a, 32'd0);
        chk("rs_queue_full", {31'd0, queue_full}, 32'd0);
        tick(); tick();
        rst_in = 1'b1;
        cnt_v = 0; cnt_r = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid === 1'b1) cnt_v++;
            if (mem_req === 1'b1) cnt_r++;
        end
        chk("rs_no_res", 32'(cnt_v), 32'd0);
        chk("rs_no_req", 32'(cnt_r), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_queue.md
LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL provide parameter QUEUE_DEPTH, default 4, the number of request entries; it SHALL be a power of two and at least 2.
REQ-002 SHALL provide parameter ID_WIDTH, default 3, the width of the instruction tag.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_in  in  1  system clock; all state changes on the rising edge.
REQ-005 rst_in  in  1  asynchronous, active-low reset.
REQ-006 rdy_in  in  1  global run enable; low pauses the block.
REQ-007 flush_pipline  in  1  mispredict flush.
REQ-008 have_ins  in  1  enqueue strobe.
REQ-009 ins_id  in  ID_WIDTH  tag of the request.
REQ-010 rs1_val, imm_val  in  32 each  base address and offset.
REQ-011 rs2_val  in  32  store data.
REQ-012 is_store  in  1  1 = store, 0 = load.
REQ-013 funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-014 queue_full  out  1  the queue holds QUEUE_DEPTH entries.
REQ-015 mem_req, mem_gnt  out, in  1 each  memory-port request and grant.
REQ-016 mem_a  out  32  byte address.
REQ-017 mem_dout  out  8  write byte.
REQ-018 mem_wr  out  1  write strobe.
REQ-019 mem_din  in  8  read byte; it carries data for the address presented one cycle earlier.
REQ-020 res_valid  out  1  one-cycle completion pulse.
REQ-021 res_ins_id  out  ID_WIDTH  completion tag.
REQ-022 res_val  out  32  load result; 0 for stores.

Function
REQ-023 Enqueue: when have_ins=1, rdy_in=1, flush_pipline=0 and queue_full=0 at an edge, SHALL store {ins_id, rs1_val+imm_val mod 2^32, rs2_val, is_store, funct3} at the tail. have_ins while full SHALL be ignored.
REQ-024 The queue SHALL be circular, with pointers wrapping modulo QUEUE_DEPTH and an occupancy count of 0..QUEUE_DEPTH. Requests SHALL complete strictly in FIFO order.
REQ-025 FSM transitions:
- IDLE→REQ when the count is nonzero.
- REQ→XFER at the edge where mem_gnt=1; the byte counter cnt is cleared to 0.
- XFER→IDLE after N cycles for a store, or N+1 cycles for a load.
N is 1, 2 or 4 for B/BU, H/HU and W respectively.
REQ-026 mem_req SHALL be 1 exactly while the state is REQ or XFER.
REQ-027 In XFER, each cycle with cnt<N SHALL drive mem_a = addr+cnt mod 2^32, then increment cnt.
- For a store, mem_wr=1 and mem_dout = rs2_val byte cnt (little-endian).
- For a load, mem_wr=0, and mem_din SHALL be captured as byte cnt-1 in cycles with cnt≥1.
REQ-028 Misaligned addresses SHALL be handled identically to aligned ones; no alignment trap is raised.
REQ-029 On XFER exit, the head entry SHALL be popped at the same edge. On the following cycle res_valid=1 and res_ins_id = the entry's tag.
- For a load, res_val SHALL be the assembled bytes: sign-extended for B and H, zero-extended for BU and HU, and unchanged for W.
- For a store, res_val SHALL be 0.
REQ-030 res_valid SHALL fall the next cycle unless another completion occurs.
REQ-031 Best case, a store is reported 3+N cycles after enqueue and a load 4+N cycles after enqueue, with mem_gnt held at 1.
REQ-032 When enqueue and pop occur at the same edge, the count SHALL be unchanged. An enqueue SHALL still be blocked if queue_full was 1 before that edge.
REQ-033 While rdy_in=0, all registers SHALL hold and mem_wr SHALL be forced to 0. The memory side holds mem_din for the same pause. flush_pipline SHALL be sampled only when rdy_in=1.
REQ-034 Flush behaviour:
- Every queued entry not in XFER SHALL be discarded, and count and pointers cleared.
- REQ SHALL return to IDLE.
- A load in XFER SHALL abort to IDLE with no result.
- A store in XFER SHALL complete its remaining bytes, and its res_valid SHALL be suppressed.

Reset
REQ-035 While rst_in=0, the following SHALL be 0 immediately, independent of the clock: state=IDLE, count, pointers, cnt, mem_req, mem_wr, mem_a, mem_dout, res_valid, res_ins_id, res_val, queue_full.
REQ-036 Reset asserted mid-transfer SHALL abandon the transfer. After reset deasserts, no res_valid SHALL be produced for it.

Verification
REQ-037 Load byte with sign extension:
- Stimulus: rs1_val=0x100, imm_val=0xFFFFFFFC, funct3=000, mem_gnt=1, memory[0xFC]=0x80.
- Required: mem_a=0xFC for one cycle, then res_val=0xFFFFFF80 with res_valid pulsed once.
REQ-038 Word store:
- Stimulus: addr 0x1001, rs2_val=0xA1B2C3D4.
- Required: mem_wr on 4 consecutive cycles with (mem_a, mem_dout) = (0x1001, D4), (0x1002, C3), (0x1003, B2), (0x1004, A1), then res_val=0.
REQ-039 Full queue:
- Stimulus: enqueue 5 requests back-to-back with mem_gnt=0.
- Required: queue_full=1 after the 4th; the 5th is dropped; after granting, exactly 4 completions arrive in tag order.
REQ-040 Address wrap:
- Stimulus: halfword load HU at 0xFFFFFFFF with bytes 0x34, 0x12.
- Required: mem_a=0xFFFFFFFF then 0x00000000; res_val=0x00001234.
REQ-041 Flush during a store:
- Stimulus: flush_pipline=1 during the 2nd byte of a word store, with 2 loads queued behind it.
- Required: bytes 3 and 4 are still written, no res_valid appears, and the count becomes 0.
REQ-042 Pause:
- Stimulus: rdy_in=0 for 3 cycles during a word load.
- Required: mem_a holds and mem_wr=0; the result after resume matches the no-pause value.
